mips_multicycle_ctrl: RTL and testbench

Main control FSM for the multicycle MIPS core, the next generation after the single-cycle controller. It sequences fetch, decode, execute, memory and writeback over multiple cycles, sharing one ALU and one unified memory. It adds a memory-ready handshake (wait states), BNE and zero-extended ANDI/ORI, a sticky illegal-op trap, and a retired-instruction counter. It sits between the instruction register outputs (op, funct), the ALU zero flag and the multicycle datapath.

---
 rtl/mips_mc_pkg.sv | 71 +++++++
 rtl/mips_mc_aludec.sv | 41 ++++
 rtl/mips_multicycle_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_mips_multicycle_ctrl.sv | 383 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_mc_pkg.sv
// mips_mc_pkg: shared types and encodings for the multicycle MIPS control FSM.
//   state_t    : main controller states
//   aluop_t    : state-derived ALU operation class handed to the ALU decoder
//   OP_* / FN_*: opcode and R-type funct field values
//   ALU_*      : alucontrol encodings
//   SRCB_*     : alusrcb encodings, PCSRC_*: pcsrc encodings
package mips_mc_pkg;

    typedef enum logic [3:0] {
        FETCH,
        DECODE,
        MEMADR,
        MEMRD,
        MEMWB,
        MEMWR,
        EXEC_R,
        EXEC_I,
        ALUWB_R,
        ALUWB_I,
        BRANCH,
        JUMP,
        TRAP
    } state_t;

    typedef enum logic [2:0] {
        ALUOP_ADD,
        ALUOP_SUB,
        ALUOP_FUNCT,
        ALUOP_AND,
        ALUOP_OR,
        ALUOP_SLT
    } aluop_t;

    // Opcodes
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;

    // R-type funct codes
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    // alucontrol encodings
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    // alusrcb encodings
    localparam logic [1:0] SRCB_REG   = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_BRIMM = 2'b11;

    // pcsrc encodings
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mips_mc_aludec.sv
// mips_mc_aludec: ALU decoder for the multicycle controller.
//   funct         in  6  R-type function field
//   aluop         in     operation class derived from the FSM state and opcode
//   alucontrol    out 3  ALU operation
//   funct_illegal out 1  funct is not a supported R-type operation (only
//                        meaningful when aluop is ALUOP_FUNCT)
module mips_mc_aludec
    import mips_mc_pkg::*;
(
    input  logic [5:0] funct,
    input  aluop_t     aluop,
    output logic [2:0] alucontrol,
    output logic       funct_illegal
);

    always_comb begin
        // NOTE: defaults first so every path assigns every output; a missing
        // assignment on some path would infer a latch.
        alucontrol    = ALU_ADD;
        funct_illegal = 1'b0;
        case (aluop)
            ALUOP_ADD: alucontrol = ALU_ADD;
            ALUOP_SUB: alucontrol = ALU_SUB;
            ALUOP_AND: alucontrol = ALU_AND;
            ALUOP_OR:  alucontrol = ALU_OR;
            ALUOP_SLT: alucontrol = ALU_SLT;
            ALUOP_FUNCT: begin
                case (funct)
                    FN_ADD:  alucontrol = ALU_ADD;
                    FN_SUB:  alucontrol = ALU_SUB;
                    FN_AND:  alucontrol = ALU_AND;
                    FN_OR:   alucontrol = ALU_OR;
                    FN_SLT:  alucontrol = ALU_SLT;
                    default: funct_illegal = 1'b1;
                endcase
            end
            default: alucontrol = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl: main control FSM of the multicycle MIPS core.
// Sequences fetch/decode/execute/memory/writeback with a memory-ready
// handshake, counts retired instructions and flags illegal instructions.
//
// Optional build macro: MIPS_MC_TRAP_EN
//   defined   : illegal op/funct enters TRAP; illegal is sticky, the FSM
//               stays there until reset.
//   undefined : illegal op/funct returns to FETCH as an uncounted NOP and
//               illegal stays 0.
//
// Ports:
//   clk, reset (async, active-high)
//   op, funct       : instruction register fields
//   zero            : ALU zero flag (branch condition)
//   mem_ready       : memory completes the current access this cycle
//   memread, memwrite, iord, irwrite, pcwrite, regdst, memtoreg, regwrite,
//   alusrca, alusrcb, immzext, pcsrc, alucontrol : datapath controls
//   illegal         : sticky illegal-instruction flag
//   instret         : retired-instruction counter (wraps)
module mips_multicycle_ctrl
    import mips_mc_pkg::*;
#(
    parameter int CNT_W  = 32,
    parameter int ALUC_W = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [5:0]        op,
    input  logic [5:0]        funct,
    input  logic              zero,
    input  logic              mem_ready,
    output logic              memread,
    output logic              memwrite,
    output logic              iord,
    output logic              irwrite,
    output logic              pcwrite,
    output logic              regdst,
    output logic              memtoreg,
    output logic              regwrite,
    output logic              alusrca,
    output logic [1:0]        alusrcb,
    output logic              immzext,
    output logic [1:0]        pcsrc,
    output logic [ALUC_W-1:0] alucontrol,
    output logic              illegal,
    output logic [CNT_W-1:0]  instret
);

`ifdef MIPS_MC_TRAP_EN
    localparam state_t BAD_NEXT = TRAP;
    localparam bit     TRAP_EN  = 1'b1;
`else
    localparam state_t BAD_NEXT = FETCH;
    localparam bit     TRAP_EN  = 1'b0;
`endif

    state_t     state;
    aluop_t     aluop;
    logic [2:0] alu_ctl;
    logic       funct_illegal;

    mips_mc_aludec u_aludec (
        .funct         (funct),
        .aluop         (aluop),
        .alucontrol    (alu_ctl),
        .funct_illegal (funct_illegal)
    );

    assign alucontrol = ALUC_W'(alu_ctl);

    // State, sticky trap flag and retire counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= FETCH;
            illegal <= 1'b0;
            instret <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register here samples
            // the values from before this clock edge.
            case (state)
                FETCH: if (mem_ready) state <= DECODE;
                DECODE: begin
                    case (op)
                        OP_LW, OP_SW:                      state <= MEMADR;
                        OP_RTYPE:                          state <= EXEC_R;
                        OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: state <= EXEC_I;
                        OP_BEQ, OP_BNE:                    state <= BRANCH;
                        OP_J:                              state <= JUMP;
                        default: begin
                            state <= BAD_NEXT;
                            if (TRAP_EN) illegal <= 1'b1;
                        end
                    endcase
                end
                MEMADR: state <= (op == OP_LW) ? MEMRD : MEMWR;
                MEMRD:  if (mem_ready) state <= MEMWB;
                MEMWR: begin
                    if (mem_ready) begin
                        state   <= FETCH;
                        instret <= instret + CNT_W'(1);
                    end
                end
                EXEC_R: begin
                    if (funct_illegal) begin
                        state <= BAD_NEXT;
                        if (TRAP_EN) illegal <= 1'b1;
                    end else begin
                        state <= ALUWB_R;
                    end
                end
                EXEC_I: state <= ALUWB_I;
                MEMWB, ALUWB_R, ALUWB_I, BRANCH, JUMP: begin
                    state   <= FETCH;
                    instret <= instret + CNT_W'(1);
                end
                TRAP:    state <= TRAP;
                default: state <= FETCH;
            endcase
        end
    end

    // Moore decode of the datapath controls; the FETCH strobes, the memory
    // strobes' exit and the branch pcwrite also look at inputs. Everything
    // is forced idle while reset is high so no access can leak out.
    always_comb begin
        memread  = 1'b0;
        memwrite = 1'b0;
        iord     = 1'b0;
        irwrite  = 1'b0;
        pcwrite  = 1'b0;
        regdst   = 1'b0;
        memtoreg = 1'b0;
        regwrite = 1'b0;
        alusrca  = 1'b0;
        alusrcb  = SRCB_REG;
        immzext  = 1'b0;
        pcsrc    = PCSRC_ALU;
        aluop    = ALUOP_ADD;
        if (!reset) begin
            case (state)
                FETCH: begin
                    memread = 1'b1;
                    alusrcb = SRCB_FOUR;
                    irwrite = mem_ready;
                    pcwrite = mem_ready;
                end
                DECODE: alusrcb = SRCB_BRIMM;
                MEMADR: begin
                    alusrca = 1'b1;
                    alusrcb = SRCB_IMM;
                end
                MEMRD: begin
                    memread = 1'b1;
                    iord    = 1'b1;
                end
                MEMWB: begin
                    regwrite = 1'b1;
                    memtoreg = 1'b1;
                end
                MEMWR: begin
                    memwrite = 1'b1;
                    iord     = 1'b1;
                end
                EXEC_R: begin
                    alusrca = 1'b1;
                    aluop   = ALUOP_FUNCT;
                end
                EXEC_I: begin
                    alusrca = 1'b1;
                    alusrcb = SRCB_IMM;
                    immzext = (op == OP_ANDI) || (op == OP_ORI);
                    case (op)
                        OP_ANDI: aluop = ALUOP_AND;
                        OP_ORI:  aluop = ALUOP_OR;
                        OP_SLTI: aluop = ALUOP_SLT;
                        default: aluop = ALUOP_ADD;
                    endcase
                end
                ALUWB_R: begin
                    regwrite = 1'b1;
                    regdst   = 1'b1;
                end
                ALUWB_I: regwrite = 1'b1;
                BRANCH: begin
                    alusrca = 1'b1;
                    pcsrc   = PCSRC_ALUOUT;
                    aluop   = ALUOP_SUB;
                    pcwrite = (op == OP_BNE) ? !zero : zero;
                end
                JUMP: begin
                    pcsrc   = PCSRC_JUMP;
                    pcwrite = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed testbench for mips_multicycle_ctrl. Inputs change 1 ns after the
// rising edge; outputs are sampled on the falling edge. The controls are
// packed into one vector and compared against hand-written per-state values.
module tb_mips_multicycle_ctrl;

    logic        clk;
    logic        reset;
    logic [5:0]  op;
    logic [5:0]  funct;
    logic        zero;
    logic        mem_ready;
    logic        memread, memwrite, iord, irwrite, pcwrite;
    logic        regdst, memtoreg, regwrite, alusrca, immzext;
    logic [1:0]  alusrcb, pcsrc;
    logic [2:0]  alucontrol;
    logic        illegal;
    logic [31:0] instret;

    int          checks;
    int          failures;
    logic [31:0] exp_instret;

    mips_multicycle_ctrl #(.CNT_W(32), .ALUC_W(3)) dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .funct      (funct),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .memread    (memread),
        .memwrite   (memwrite),
        .iord       (iord),
        .irwrite    (irwrite),
        .pcwrite    (pcwrite),
        .regdst     (regdst),
        .memtoreg   (memtoreg),
        .regwrite   (regwrite),
        .alusrca    (alusrca),
        .alusrcb    (alusrcb),
        .immzext    (immzext),
        .pcsrc      (pcsrc),
        .alucontrol (alucontrol),
        .illegal    (illegal),
        .instret    (instret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {memread,memwrite,iord,irwrite,pcwrite,regdst,memtoreg,regwrite,
    //  alusrca,alusrcb,immzext,pcsrc,alucontrol}
    logic [16:0] obs;
    assign obs = {memread, memwrite, iord, irwrite, pcwrite, regdst, memtoreg,
                  regwrite, alusrca, alusrcb, immzext, pcsrc, alucontrol};

    function automatic logic [16:0] mk(
        input logic mr, input logic mw, input logic io, input logic irw,
        input logic pcw, input logic rd, input logic m2r, input logic rw,
        input logic sa, input logic [1:0] sb, input logic iz,
        input logic [1:0] ps, input logic [2:0] ac);
        return {mr, mw, io, irw, pcw, rd, m2r, rw, sa, sb, iz, ps, ac};
    endfunction

    localparam logic [16:0] V_IDLE     = mk(0,0,0,0,0,0,0,0,0,2'b00,0,2'b00,3'b010);
    localparam logic [16:0] V_FETCH    = mk(1,0,0,1,1,0,0,0,0,2'b01,0,2'b00,3'b010);
    localparam logic [16:0] V_FETCH_W  = mk(1,0,0,0,0,0,0,0,0,2'b01,0,2'b00,3'b010);
    localparam logic [16:0] V_DECODE   = mk(0,0,0,0,0,0,0,0,0,2'b11,0,2'b00,3'b010);
    localparam logic [16:0] V_EXR_ADD  = mk(0,0,0,0,0,0,0,0,1,2'b00,0,2'b00,3'b010);
    localparam logic [16:0] V_ALUWB_R  = mk(0,0,0,0,0,1,0,1,0,2'b00,0,2'b00,3'b010);
    localparam logic [16:0] V_MEMADR   = mk(0,0,0,0,0,0,0,0,1,2'b10,0,2'b00,3'b010);
    localparam logic [16:0] V_MEMRD    = mk(1,0,1,0,0,0,0,0,0,2'b00,0,2'b00,3'b010);
    localparam logic [16:0] V_MEMWB    = mk(0,0,0,0,0,0,1,1,0,2'b00,0,2'b00,3'b010);
    localparam logic [16:0] V_MEMWR    = mk(0,1,1,0,0,0,0,0,0,2'b00,0,2'b00,3'b010);
    localparam logic [16:0] V_EXI_ORI  = mk(0,0,0,0,0,0,0,0,1,2'b10,1,2'b00,3'b001);
    localparam logic [16:0] V_EXI_SLTI = mk(0,0,0,0,0,0,0,0,1,2'b10,0,2'b00,3'b111);
    localparam logic [16:0] V_ALUWB_I  = mk(0,0,0,0,0,0,0,1,0,2'b00,0,2'b00,3'b010);
    localparam logic [16:0] V_BR_TAKE  = mk(0,0,0,0,1,0,0,0,1,2'b00,0,2'b01,3'b110);
    localparam logic [16:0] V_BR_NOT   = mk(0,0,0,0,0,0,0,0,1,2'b00,0,2'b01,3'b110);
    localparam logic [16:0] V_JUMP     = mk(0,0,0,0,1,0,0,0,0,2'b00,0,2'b10,3'b010);

    // Reset and leave the FSM parked in FETCH, 1 ns after a rising edge.
    task automatic do_reset();
        reset = 1'b1;
        mem_ready = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        exp_instret = '0;
    endtask

    task automatic test_reset();
        reset = 1'b1; op = 6'b0; funct = 6'b0; zero = 1'b0; mem_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (obs !== V_IDLE) begin
            failures++;
            $display("FAIL reset_strobes got=%b want=%b", obs, V_IDLE);
        end
        checks++;
        if (instret !== 32'd0 || illegal !== 1'b0) begin
            failures++;
            $display("FAIL reset_regs got instret=%0d illegal=%b want 0/0", instret, illegal);
        end
        do_reset();
        mem_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (obs !== V_FETCH_W) begin
            failures++;
            $display("FAIL reset_fetch_wait got=%b want=%b", obs, V_FETCH_W);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_add();
        logic [16:0] e [4] = '{V_FETCH, V_DECODE, V_EXR_ADD, V_ALUWB_R};
        op = 6'b000000; funct = 6'b100000; mem_ready = 1'b1; zero = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (obs !== e[i]) begin
                failures++;
                $display("FAIL add_cyc%0d got=%b want=%b", i, obs, e[i]);
            end
            @(posedge clk); #1;
        end
        exp_instret = exp_instret + 1;
        checks++;
        if (instret !== exp_instret) begin
            failures++;
            $display("FAIL add_instret got=%0d want=%0d", instret, exp_instret);
        end
    endtask

    task automatic test_lw_wait();
        logic [16:0] e [7] = '{V_FETCH, V_DECODE, V_MEMADR, V_MEMRD, V_MEMRD, V_MEMRD, V_MEMWB};
        logic        mr [7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        int          nrw = 0;
        op = 6'b100011; funct = 6'b0;
        for (int i = 0; i < 7; i++) begin
            mem_ready = mr[i];
            @(negedge clk);
            checks++;
            if (obs !== e[i]) begin
                failures++;
                $display("FAIL lw_cyc%0d got=%b want=%b", i, obs, e[i]);
            end
            if (regwrite === 1'b1) nrw++;
            @(posedge clk); #1;
        end
        checks++;
        if (nrw != 1) begin
            failures++;
            $display("FAIL lw_regwrite_count got=%0d want=1", nrw);
        end
        mem_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (obs !== V_FETCH_W) begin
            failures++;
            $display("FAIL lw_back_in_fetch got=%b want=%b", obs, V_FETCH_W);
        end
        @(posedge clk); #1;
        exp_instret = exp_instret + 1;
        checks++;
        if (instret !== exp_instret) begin
            failures++;
            $display("FAIL lw_instret got=%0d want=%0d", instret, exp_instret);
        end
    endtask

    task automatic test_branch();
        logic [5:0]  ops [3] = '{6'b000100, 6'b000101, 6'b000101};
        logic        zs  [3] = '{1'b1, 1'b1, 1'b0};
        logic [16:0] br  [3] = '{V_BR_TAKE, V_BR_NOT, V_BR_TAKE};
        mem_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            op = ops[k]; zero = zs[k];
            for (int i = 0; i < 3; i++) begin
                @(negedge clk);
                checks++;
                if (obs !== ((i == 0) ? V_FETCH : (i == 1) ? V_DECODE : br[k])) begin
                    failures++;
                    $display("FAIL branch%0d_cyc%0d got=%b", k, i, obs);
                end
                @(posedge clk); #1;
            end
            exp_instret = exp_instret + 1;
        end
        zero = 1'b0;
        checks++;
        if (instret !== exp_instret) begin
            failures++;
            $display("FAIL branch_instret got=%0d want=%0d", instret, exp_instret);
        end
    endtask

    task automatic test_itype();
        logic [5:0]  ops [2] = '{6'b001101, 6'b001010};
        logic [16:0] ex  [2] = '{V_EXI_ORI, V_EXI_SLTI};
        mem_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            op = ops[k];
            for (int i = 0; i < 4; i++) begin
                @(negedge clk);
                checks++;
                if (obs !== ((i == 0) ? V_FETCH : (i == 1) ? V_DECODE :
                             (i == 2) ? ex[k] : V_ALUWB_I)) begin
                    failures++;
                    $display("FAIL itype%0d_cyc%0d got=%b", k, i, obs);
                end
                @(posedge clk); #1;
            end
            exp_instret = exp_instret + 1;
        end
        checks++;
        if (instret !== exp_instret) begin
            failures++;
            $display("FAIL itype_instret got=%0d want=%0d", instret, exp_instret);
        end
    endtask

    task automatic test_jump_sw();
        logic [16:0] ej [3] = '{V_FETCH, V_DECODE, V_JUMP};
        logic [16:0] es [4] = '{V_FETCH, V_DECODE, V_MEMADR, V_MEMWR};
        mem_ready = 1'b1;
        op = 6'b000010;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (obs !== ej[i]) begin
                failures++;
                $display("FAIL j_cyc%0d got=%b want=%b", i, obs, ej[i]);
            end
            @(posedge clk); #1;
        end
        op = 6'b101011;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (obs !== es[i]) begin
                failures++;
                $display("FAIL sw_cyc%0d got=%b want=%b", i, obs, es[i]);
            end
            @(posedge clk); #1;
        end
        exp_instret = exp_instret + 2;
        checks++;
        if (instret !== exp_instret) begin
            failures++;
            $display("FAIL jsw_instret got=%0d want=%0d", instret, exp_instret);
        end
    endtask

    task automatic test_sw_reset();
        logic [16:0] es [3] = '{V_FETCH, V_DECODE, V_MEMADR};
        op = 6'b101011; mem_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (obs !== es[i]) begin
                failures++;
                $display("FAIL swr_cyc%0d got=%b want=%b", i, obs, es[i]);
            end
            @(posedge clk); #1;
        end
        mem_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (obs !== V_MEMWR) begin
            failures++;
            $display("FAIL swr_memwr_wait got=%b want=%b", obs, V_MEMWR);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (obs !== V_IDLE || instret !== 32'd0) begin
            failures++;
            $display("FAIL swr_async got=%b instret=%0d want=%b instret=0", obs, instret, V_IDLE);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        exp_instret = '0;
        @(negedge clk);
        checks++;
        if (obs !== V_FETCH_W) begin
            failures++;
            $display("FAIL swr_after_reset got=%b want=%b", obs, V_FETCH_W);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_illegal();
        logic [16:0] ef [3] = '{V_FETCH, V_DECODE, V_EXR_ADD};
        // R-type with unsupported funct 000000
        op = 6'b000000; funct = 6'b000000; mem_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (obs !== ef[i]) begin
                failures++;
                $display("FAIL badfn_cyc%0d got=%b want=%b", i, obs, ef[i]);
            end
            @(posedge clk); #1;
        end
        mem_ready = 1'b0;
        @(negedge clk);
`ifdef MIPS_MC_TRAP_EN
        checks++;
        if (obs !== V_IDLE || illegal !== 1'b1) begin
            failures++;
            $display("FAIL badfn_trap got=%b illegal=%b want=%b illegal=1", obs, illegal, V_IDLE);
        end
`else
        checks++;
        if (obs !== V_FETCH_W || illegal !== 1'b0) begin
            failures++;
            $display("FAIL badfn_nop got=%b illegal=%b want=%b illegal=0", obs, illegal, V_FETCH_W);
        end
`endif
        checks++;
        if (instret !== exp_instret) begin
            failures++;
            $display("FAIL badfn_instret got=%0d want=%0d", instret, exp_instret);
        end
        @(posedge clk); #1;
        do_reset();

        // Illegal opcode 111111
        op = 6'b111111; mem_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (obs !== ((i == 0) ? V_FETCH : V_DECODE)) begin
                failures++;
                $display("FAIL badop_cyc%0d got=%b", i, obs);
            end
            @(posedge clk); #1;
        end
`ifdef MIPS_MC_TRAP_EN
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (obs !== V_IDLE || illegal !== 1'b1) begin
                failures++;
                $display("FAIL badop_trap%0d got=%b illegal=%b want=%b illegal=1", i, obs, illegal, V_IDLE);
            end
            @(posedge clk); #1;
        end
`else
        mem_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (obs !== V_FETCH_W || illegal !== 1'b0) begin
            failures++;
            $display("FAIL badop_nop got=%b illegal=%b want=%b illegal=0", obs, illegal, V_FETCH_W);
        end
        @(posedge clk); #1;
`endif
        checks++;
        if (instret !== exp_instret) begin
            failures++;
            $display("FAIL badop_instret got=%0d want=%0d", instret, exp_instret);
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        exp_instret = '0;
        test_reset();
        test_add();
        test_lw_wait();
        test_branch();
        test_itype();
        test_jump_sw();
        test_sw_reset();
        test_illegal();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
